// File: rtl/pipe_stage.sv
// Elastic pipeline register: LANES x DATA_W payload under a valid/ready handshake, with flush.
// Latency: one cycle from accept to out_valid/out_data; one beat per cycle while out_ready=1.
// Backpressure: PIPE_SKID_EN adds a skid slot and registered in_ready; otherwise in_ready = out_ready || !out_valid.
module pipe_stage #(
   parameter int DATA_W = 32,
   parameter int LANES  = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic [1:0]              occupancy
);

   localparam int W = LANES * DATA_W;

   // State encoding equals the number of held entries, so occupancy is the state itself.
`ifdef PIPE_SKID_EN
   typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_FULL = 2'd1, ST_SKID = 2'd2} state_t;
`else
   typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_FULL = 2'd1} state_t;
`endif

   state_t         state_q, state_d;
   logic [W-1:0]   main_q, main_d;
   logic           in_xfer, out_xfer;

`ifdef PIPE_SKID_EN
   logic [W-1:0]   skid_q, skid_d;
   logic           in_ready_q, in_ready_d;
   assign in_ready = in_ready_q;
`else
   assign in_ready = out_ready || !out_valid;
`endif

   // The main slot is kept zero whenever it is empty, so out_data is a plain register output.
   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = main_q;
   assign occupancy = state_q;

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;

   // Next-state and slot updates; reset and flush override everything and clear all slots.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
`ifdef PIPE_SKID_EN
      skid_d  = skid_q;
`endif
      case (state_q)
         ST_EMPTY: begin
            if (in_xfer) begin
               main_d  = in_data;
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            if (in_xfer && out_xfer) begin
               main_d = in_data;
            end else if (out_xfer) begin
               main_d  = '0;
               state_d = ST_EMPTY;
            end
`ifdef PIPE_SKID_EN
            else if (in_xfer) begin
               skid_d  = in_data;
               state_d = ST_SKID;
            end
`endif
         end
`ifdef PIPE_SKID_EN
         ST_SKID: begin
            if (out_xfer) begin
               main_d  = skid_q;
               skid_d  = '0;
               state_d = ST_FULL;
            end
         end
`endif
         default: begin
            main_d  = '0;
            state_d = ST_EMPTY;
         end
      endcase
      if (reset || flush) begin
         state_d = ST_EMPTY;
         main_d  = '0;
`ifdef PIPE_SKID_EN
         skid_d  = '0;
`endif
      end
`ifdef PIPE_SKID_EN
      // Registered in_ready looks at the next state, so it never depends on out_ready combinationally.
      in_ready_d = (state_d != ST_SKID);
`endif
   end

   // State and payload registers; synchronous reset is folded into the _d terms above.
   always_ff @(posedge clk) begin
      state_q <= state_d;
      main_q  <= main_d;
`ifdef PIPE_SKID_EN
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
`endif
   end

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: scoreboard queue of accepted beats, popped on each out transfer.
// Latency: checks are made one half cycle after the edge on which the DUT registers update.
// Backpressure: stall, flush, reset-mid-stall and random out_ready; skid build selected by PIPE_SKID_EN.
module tb_pipe_stage;

   localparam int DATA_W = 32;
   localparam int LANES  = 4;
   localparam int W      = DATA_W * LANES;
`ifdef PIPE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif
   localparam int MAXOCC = SKID ? 2 : 1;

   logic         clk = 1'b0;
   logic         reset, flush, in_valid, out_ready;
   logic [W-1:0] in_data;
   logic         in_ready, out_valid;
   logic [W-1:0] out_data;
   logic [1:0]   occupancy;

   // Parameter-sweep instances
   logic         s8_iv, s8_ir, s8_ov;
   logic [7:0]   s8_id, s8_od;
   logic [1:0]   s8_occ;
   logic         s6_iv, s6_ir, s6_ov;
   logic [191:0] s6_id, s6_od;
   logic [1:0]   s6_occ;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] exp_q[$];
   logic         did_in, did_out;
   logic [W-1:0] obs_dat, exp_dat;

   always #5 clk = ~clk;

   pipe_stage #(.DATA_W(DATA_W), .LANES(LANES)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy)
   );

   pipe_stage #(.DATA_W(8), .LANES(1)) dut_w8 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(s8_iv), .in_ready(s8_ir), .in_data(s8_id),
      .out_valid(s8_ov), .out_ready(1'b1), .out_data(s8_od),
      .occupancy(s8_occ)
   );

   pipe_stage #(.DATA_W(32), .LANES(6)) dut_l6 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(s6_iv), .in_ready(s6_ir), .in_data(s6_id),
      .out_valid(s6_ov), .out_ready(1'b1), .out_data(s6_od),
      .occupancy(s6_occ)
   );

   function automatic logic [W-1:0] rand_beat();
      logic [W-1:0] v;
      for (int k = 0; k < LANES; k++) v[k*DATA_W +: DATA_W] = $urandom;
      return v;
   endfunction

   // Drives one cycle starting at a negedge, updates the reference queue, returns at the next negedge.
   task automatic drive(input logic iv, input logic [W-1:0] id, input logic ordy,
                        input logic fl, input logic rs);
      in_valid = iv; in_data = id; out_ready = ordy; flush = fl; reset = rs;
      #1;
      did_in  = iv && in_ready;
      did_out = out_valid && ordy;
      obs_dat = out_data;
      exp_dat = '1;
      if (did_out && exp_q.size() > 0) exp_dat = exp_q.pop_front();
      if (rs || fl) exp_q.delete();
      else if (did_in) exp_q.push_back(id);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_stream();
      logic [W-1:0] base, beat, first;
      base  = {32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_3004, 32'h0000_3003};
      first = base;
      for (int i = 0; i < 8; i++) begin
         beat = base ^ (W'(i) << 64);
         drive(1'b1, beat, 1'b1, 1'b0, 1'b0);
         if (i == 0) begin
            n_checks++; if (out_data !== first) begin n_fail++; $display("FAIL stream_first_latency got=%h exp=%h", out_data, first); end
         end
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_out_valid beat=%0d got=%b exp=1", i, out_valid); end
         n_checks++; if (did_in !== 1'b1) begin n_fail++; $display("FAIL stream_accept beat=%0d got=%b exp=1", i, did_in); end
         n_checks++; if (did_out !== (i != 0)) begin n_fail++; $display("FAIL stream_out_xfer beat=%0d got=%b exp=%b", i, did_out, (i != 0)); end
         if (did_out) begin
            n_checks++; if (obs_dat !== exp_dat) begin n_fail++; $display("FAIL stream_data beat=%0d got=%h exp=%h", i, obs_dat, exp_dat); end
         end
      end
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n_checks++; if (obs_dat !== (base ^ (W'(7) << 64))) begin n_fail++; $display("FAIL stream_last got=%h exp=%h", obs_dat, base ^ (W'(7) << 64)); end
      n_checks++; if (out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL stream_drained got_vld=%b got_dat=%h exp=0/0", out_valid, out_data); end
   endtask

   task automatic test_stall();
      logic [W-1:0] a, b;
      logic [W-1:0] pops[$];
      logic         pend;
      a = rand_beat();
      b = rand_beat();
      drive(1'b1, a, 1'b0, 1'b0, 1'b0);
      pend = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(pend, b, 1'b0, 1'b0, 1'b0);
         if (did_in) pend = 1'b0;
         n_checks++; if (out_data !== a) begin n_fail++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", i, out_data, a); end
      end
      n_checks++; if (occupancy !== 2'(MAXOCC)) begin n_fail++; $display("FAIL stall_occupancy got=%0d exp=%0d", occupancy, MAXOCC); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
      n_checks++; if (pend !== !SKID) begin n_fail++; $display("FAIL stall_skid_accept pending=%b exp=%b", pend, !SKID); end
      for (int i = 0; i < 6; i++) begin
         drive(pend, b, 1'b1, 1'b0, 1'b0);
         if (did_in) pend = 1'b0;
         if (did_out) pops.push_back(obs_dat);
      end
      n_checks++; if (pops.size() != 2) begin n_fail++; $display("FAIL stall_pop_count got=%0d exp=2", pops.size()); end
      if (pops.size() == 2) begin
         n_checks++; if (pops[0] !== a) begin n_fail++; $display("FAIL stall_order_a got=%h exp=%h", pops[0], a); end
         n_checks++; if (pops[1] !== b) begin n_fail++; $display("FAIL stall_order_b got=%h exp=%h", pops[1], b); end
      end
   endtask

   task automatic test_flush_full();
      logic [W-1:0] a, b;
      a = rand_beat();
      b = rand_beat();
      drive(1'b1, a, 1'b0, 1'b0, 1'b0);
      drive(1'b1, b, 1'b0, 1'b1, 1'b0);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
      n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL flush_out_data got=%h exp=0", out_data); end
      n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_occupancy got=%0d exp=0", occupancy); end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
         n_checks++; if (did_out !== 1'b0) begin n_fail++; $display("FAIL flush_leak cyc=%0d got=%h exp=none", i, obs_dat); end
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, rand_beat(), 1'b1, 1'b1, 1'b0);
         n_checks++; if (in_ready !== 1'b1 || occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_b2b cyc=%0d got_rdy=%b got_occ=%0d exp=1/0", i, in_ready, occupancy); end
      end
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_b2b_after got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_mid_stall();
      logic [W-1:0] a, b, c;
      a = rand_beat(); b = rand_beat(); c = rand_beat();
      drive(1'b1, a, 1'b0, 1'b0, 1'b0);
      drive(1'b1, b, 1'b0, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      n_checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1)
         begin n_fail++; $display("FAIL rst_stall_state got_vld=%b got_occ=%0d got_rdy=%b exp=0/0/1", out_valid, occupancy, in_ready); end
      drive(1'b1, c, 1'b1, 1'b0, 1'b0);
      n_checks++; if (did_out !== 1'b0) begin n_fail++; $display("FAIL rst_stall_leak got=%h exp=none", obs_dat); end
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n_checks++; if (did_out !== 1'b1 || obs_dat !== c) begin n_fail++; $display("FAIL rst_stall_c got_xfer=%b got=%h exp=%h", did_out, obs_dat, c); end
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n_checks++; if (did_out !== 1'b0) begin n_fail++; $display("FAIL rst_stall_alone got=%h exp=none", obs_dat); end
   endtask

   task automatic test_random();
      logic         pend, ordy, exp_rdy;
      logic [W-1:0] pend_dat;
      pend = 1'b0; pend_dat = '0;
      for (int i = 0; i < 1000; i++) begin
         if (!pend) begin
            pend     = ($urandom_range(0, 3) != 0);
            pend_dat = rand_beat();
         end
         ordy = (i % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         drive(pend, pend_dat, ordy, 1'b0, 1'b0);
         if (did_in) pend = 1'b0;
         if (did_out) begin
            n_checks++; if (obs_dat !== exp_dat) begin n_fail++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, obs_dat, exp_dat); end
         end
         exp_rdy = SKID ? (exp_q.size() < 2) : (out_ready || exp_q.size() == 0);
         n_checks++; if (occupancy !== 2'(exp_q.size()) || occupancy > 2'(MAXOCC))
            begin n_fail++; $display("FAIL rand_occupancy cyc=%0d got=%0d exp=%0d", i, occupancy, exp_q.size()); end
         n_checks++; if (out_valid !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", i, out_valid, exp_q.size() != 0); end
         n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", i, in_ready, exp_rdy); end
      end
      for (int i = 0; i < 4; i++) begin
         drive(pend, pend_dat, 1'b1, 1'b0, 1'b0);
         if (did_in) pend = 1'b0;
         if (did_out) begin
            n_checks++; if (obs_dat !== exp_dat) begin n_fail++; $display("FAIL rand_drain cyc=%0d got=%h exp=%h", i, obs_dat, exp_dat); end
         end
      end
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n_checks++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin n_fail++; $display("FAIL rand_final got_vld=%b model_left=%0d exp=0/0", out_valid, exp_q.size()); end
   endtask

   task automatic test_param_sweep();
      logic [7:0]   v8;
      logic [191:0] v6;
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         v8 = 8'($urandom_range(0, 255));
         for (int k = 0; k < 6; k++) v6[k*32 +: 32] = $urandom;
         s8_iv = 1'b1; s8_id = v8;
         s6_iv = 1'b1; s6_id = v6;
         @(posedge clk);
         @(negedge clk);
         n_checks++; if (s8_ov !== 1'b1 || s8_od !== v8) begin n_fail++; $display("FAIL sweep_w8 beat=%0d got_vld=%b got=%h exp=%h", i, s8_ov, s8_od, v8); end
         for (int k = 0; k < 6; k++) begin
            n_checks++; if (s6_od[k*32 +: 32] !== v6[k*32 +: 32])
               begin n_fail++; $display("FAIL sweep_l6 beat=%0d lane=%0d got=%h exp=%h", i, k, s6_od[k*32 +: 32], v6[k*32 +: 32]); end
         end
      end
      s8_iv = 1'b0; s8_id = '0;
      s6_iv = 1'b0; s6_id = '0;
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (s8_ov !== 1'b0 || s8_od !== 8'd0 || s6_ov !== 1'b0 || s6_od !== '0)
         begin n_fail++; $display("FAIL sweep_drain got_w8=%b/%h got_l6=%b exp=0", s8_ov, s8_od, s6_ov); end
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      s8_iv = 1'b0; s8_id = '0; s6_iv = 1'b0; s6_id = '0;
      @(negedge clk);
      test_reset();
      test_stream();
      test_stall();
      test_flush_full();
      test_reset_mid_stall();
      test_random();
      test_param_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
